// File: rtl/beta_dmem_responder_if.sv
// Data-port bus between the Beta core (master) and its memory responder (slave).
`timescale 1ns/1ps
interface beta_dmem_responder_if;
    logic [31:0] DataAddress;
    logic [31:0] DataWrite;
    logic        WriteEnable;
    logic        ReadEnable;
    logic [31:0] DataRead;
    logic        dataReady;
    logic        dMemfault;
    logic        busy;

    modport master (
        output DataAddress, DataWrite, WriteEnable, ReadEnable,
        input  DataRead, dataReady, dMemfault, busy
    );

    modport slave (
        input  DataAddress, DataWrite, WriteEnable, ReadEnable,
        output DataRead, dataReady, dMemfault, busy
    );
endinterface

// File: rtl/beta_dmem_responder.sv
// Beta data-memory responder: word RAM behind a fixed-latency request/response FSM.
// A request seen in IDLE completes with a one-cycle dataReady pulse LATENCY+1
// cycles later; misaligned, out-of-range or read+write requests report dMemfault
// and never touch the RAM.
`timescale 1ns/1ps
module beta_dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    beta_dmem_responder_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
    // First byte address past the end of the RAM; 33 bits so ADDR_WIDTH=30 fits.
    localparam logic [32:0] ADDR_LIMIT = 33'(1) << (ADDR_WIDTH + 2);

    // Elaboration-time guard on the parameter ranges the counter and RAM support.
    if (LATENCY > 15) begin : g_bad_latency
        $error("beta_dmem_responder: LATENCY must be in 0..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
        $error("beta_dmem_responder: ADDR_WIDTH must be in 1..30");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Latched request: only the word index is kept, the rest of the address
    // only matters for the fault decision taken at acceptance.
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;
    logic                    fault_q, fault_d;
    // Registered outputs.
    logic                    ready_q, ready_d;
    logic                    mfault_q, mfault_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    busy_q, busy_d;

    logic                    req_c;
    logic                    fault_in_c;
    logic                    enter_resp_c;
    logic                    mem_we_c;

    logic [31:0]             mem_q [DEPTH];

    // Request presence and fault classification of the incoming request.
    always_comb begin
        req_c      = bus.ReadEnable | bus.WriteEnable;
        fault_in_c = (bus.DataAddress[1:0] != 2'b00)
                   | (33'(bus.DataAddress) >= ADDR_LIMIT)
                   | (bus.ReadEnable & bus.WriteEnable);
    end

    // Next-state, request latch, RAM commit and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        re_d         = re_q;
        fault_d      = fault_q;
        ready_d      = 1'b0;
        mfault_d     = 1'b0;
        rdata_d      = rdata_q;
        busy_d       = 1'b0;
        enter_resp_c = 1'b0;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    idx_d   = bus.DataAddress[ADDR_WIDTH+1:2];
                    wdata_d = bus.DataWrite;
                    we_d    = bus.WriteEnable;
                    re_d    = bus.ReadEnable;
                    fault_d = fault_in_c;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The _d request values are the ones in effect on the edge entering RESP,
        // covering both the LATENCY==0 (straight from IDLE) and WAIT paths.
        enter_resp_c = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
        if (enter_resp_c) begin
            ready_d  = 1'b1;
            mfault_d = fault_d;
            rdata_d  = (re_d && !fault_d) ? mem_q[idx_d] : 32'h0;
        end
        // A reset on the committing edge discards the write.
        mem_we_c = rst & enter_resp_c & we_d & ~fault_d;
    end

    // State, request latch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            fault_q  <= 1'b0;
            ready_q  <= 1'b0;
            mfault_q <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            fault_q  <= fault_d;
            ready_q  <= ready_d;
            mfault_q <= mfault_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    // Word RAM; contents are neither cleared nor disturbed by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign bus.DataRead  = rdata_q;
    assign bus.dataReady = ready_q;
    assign bus.dMemfault = mfault_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_beta_dmem_responder.sv
// Self-checking bench for beta_dmem_responder: three instances (LATENCY 0, 2, 3,
// ADDR_WIDTH 10) driven by directed and randomized transactions and compared
// against a word-addressed reference memory kept in the bench.
`timescale 1ns/1ps
module tb_beta_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst2, rst3;

    beta_dmem_responder_if bus0();
    beta_dmem_responder_if bus2();
    beta_dmem_responder_if bus3();

    // Instance selector value equals the instance's LATENCY.
    beta_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    beta_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    beta_dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory: key = instance*65536 + word index; absent key = unknown.
    logic [31:0] mm [int];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic re);
        case (sel)
            0: begin bus0.DataAddress = a; bus0.DataWrite = d; bus0.WriteEnable = we; bus0.ReadEnable = re; end
            2: begin bus2.DataAddress = a; bus2.DataWrite = d; bus2.WriteEnable = we; bus2.ReadEnable = re; end
            3: begin bus3.DataAddress = a; bus3.DataWrite = d; bus3.WriteEnable = we; bus3.ReadEnable = re; end
            default: ;
        endcase
    endtask

    task automatic peek(input int sel, output logic rdy, output logic flt,
                        output logic bsy, output logic [31:0] rd);
        case (sel)
            0: begin rdy = bus0.dataReady; flt = bus0.dMemfault; bsy = bus0.busy; rd = bus0.DataRead; end
            2: begin rdy = bus2.dataReady; flt = bus2.dMemfault; bsy = bus2.busy; rd = bus2.DataRead; end
            3: begin rdy = bus3.dataReady; flt = bus3.dMemfault; bsy = bus3.busy; rd = bus3.DataRead; end
            default: begin rdy = 1'bx; flt = 1'bx; bsy = 1'bx; rd = 'x; end
        endcase
    endtask

    // One full transaction: request in cycle N, expect busy N+1..N+1+lat and
    // a single dataReady in N+1+lat. The request stays asserted after RESP
    // unless drop is set (dropped in N+1); the caller idles or replaces it.
    task automatic txn(input string name, input int sel, input logic [31:0] a,
                       input logic [31:0] d, input logic we, input logic re, input bit drop);
        logic rdy, flt, bsy;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        bit exp_fault, known;
        int key;
        exp_fault = (a[1:0] != 2'b00) || (a >= 32'h0000_1000) || (we && re);
        key       = sel * 65536 + int'(a[11:2]);
        exp_rd    = 32'h0;
        known     = 1'b1;
        if (re && !exp_fault) begin
            if (mm.exists(key)) exp_rd = mm[key];
            else known = 1'b0;
        end
        if (we && !exp_fault) mm[key] = d;

        @(posedge clk); #1;
        drive(sel, a, d, we, re);
        @(negedge clk);
        peek(sel, rdy, flt, bsy, rd);
        n_checks++;
        if ({rdy, bsy} !== 2'b00)
            $display("FAIL %s request-cycle ready/busy: got %b%b want 00", name, rdy, bsy);
        else n_pass++;

        for (int c = 1; c <= sel + 1; c++) begin
            @(posedge clk); #1;
            if (drop && c == 1) drive(sel, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            peek(sel, rdy, flt, bsy, rd);
            n_checks++;
            if ({rdy, bsy} !== {(c == sel + 1), 1'b1})
                $display("FAIL %s ready/busy at N+%0d: got %b%b want %b1", name, c, rdy, bsy, (c == sel + 1));
            else n_pass++;
        end

        n_checks++;
        if (flt !== exp_fault)
            $display("FAIL %s dMemfault: got %b want %b", name, flt, exp_fault);
        else n_pass++;
        if (known) begin
            n_checks++;
            if (rd !== exp_rd)
                $display("FAIL %s DataRead: got %h want %h", name, rd, exp_rd);
            else n_pass++;
        end
    endtask

    // Drop the request in the cycle after RESP and confirm the block is idle.
    task automatic idle(input string name, input int sel);
        logic rdy, flt, bsy;
        logic [31:0] rd;
        @(posedge clk); #1;
        drive(sel, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        peek(sel, rdy, flt, bsy, rd);
        n_checks++;
        if ({rdy, flt, bsy} !== 3'b000)
            $display("FAIL %s post-resp ready/fault/busy: got %b%b%b want 000", name, rdy, flt, bsy);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic rdy, flt, bsy;
        logic [31:0] rd;
        int sels [3] = '{0, 2, 3};
        foreach (sels[i]) drive(sels[i], 32'h0, 32'h0, 1'b0, 1'b0);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        foreach (sels[i]) begin
            peek(sels[i], rdy, flt, bsy, rd);
            n_checks++;
            if ({rdy, flt, bsy} !== 3'b000 || rd !== 32'h0)
                $display("FAIL reset_state[%0d]: got rdy=%b flt=%b busy=%b rd=%h want all 0",
                         sels[i], rdy, flt, bsy, rd);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    endtask

    task automatic test_write_read();
        txn("wr_deadbeef", 2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        idle("wr_deadbeef", 2);
        txn("rd_deadbeef", 2, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("rd_deadbeef", 2);
    endtask

    task automatic test_faults();
        txn("misaligned_wr", 2, 32'h0000_0012, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        idle("misaligned_wr", 2);
        txn("rd_after_misaligned", 2, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("rd_after_misaligned", 2);
        txn("oob_rd", 2, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("oob_rd", 2);
        txn("wr_top_word", 2, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);
        idle("wr_top_word", 2);
        txn("rd_top_word", 2, 32'h0000_0FFC, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("rd_top_word", 2);
        txn("both_enables", 2, 32'h0000_0010, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0);
        idle("both_enables", 2);
        txn("rd_after_both", 2, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("rd_after_both", 2);
    endtask

    task automatic test_back_to_back();
        txn("b2b_wr0", 0, 32'h0000_0000, 32'h1111_0000, 1'b1, 1'b0, 1'b0);
        idle("b2b_wr0", 0);
        txn("b2b_wr4", 0, 32'h0000_0004, 32'h2222_0004, 1'b1, 1'b0, 1'b0);
        idle("b2b_wr4", 0);
        // Second request replaces the first in the cycle after dataReady.
        txn("b2b_rd0", 0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
        txn("b2b_rd4", 0, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("b2b_rd4", 0);
    endtask

    task automatic test_reset_mid();
        logic rdy, flt, bsy;
        logic [31:0] rd;
        txn("pre_wr20", 3, 32'h0000_0020, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
        idle("pre_wr20", 3);
        @(posedge clk); #1;                      // cycle N
        drive(3, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 1'b0);
        @(posedge clk); #1;                      // cycle N+1
        @(negedge clk);
        peek(3, rdy, flt, bsy, rd);
        n_checks++;
        if (bsy !== 1'b1) $display("FAIL abort busy_before_reset: got %b want 1", bsy);
        else n_pass++;
        @(posedge clk); #1;                      // cycle N+2
        rst3 = 1'b0;
        @(posedge clk); #1;                      // cycle N+3
        rst3 = 1'b1;
        drive(3, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            peek(3, rdy, flt, bsy, rd);
            n_checks++;
            if ({rdy, flt, bsy} !== 3'b000 || rd !== 32'h0)
                $display("FAIL abort outputs at N+%0d: got rdy=%b flt=%b busy=%b rd=%h want all 0",
                         c, rdy, flt, bsy, rd);
            else n_pass++;
            @(posedge clk); #1;
        end
        txn("rd20_after_abort", 3, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("rd20_after_abort", 3);
    endtask

    task automatic test_drop();
        txn("drop_wr_l2", 2, 32'h0000_0030, 32'hC0FF_EE02, 1'b1, 1'b0, 1'b1);
        idle("drop_wr_l2", 2);
        txn("drop_rd_l2", 2, 32'h0000_0030, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("drop_rd_l2", 2);
        txn("drop_wr_l3", 3, 32'h0000_0034, 32'hC0FF_EE03, 1'b1, 1'b0, 1'b1);
        idle("drop_wr_l3", 3);
        txn("drop_rd_l3", 3, 32'h0000_0034, 32'h0, 1'b0, 1'b1, 1'b0);
        idle("drop_rd_l3", 3);
    endtask

    task automatic test_random();
        int sels [3] = '{0, 2, 3};
        int sel, prev_sel, kind;
        bit pending;
        logic [31:0] a, d;
        logic we, re;
        pending  = 1'b0;
        prev_sel = 0;
        for (int i = 0; i < 60; i++) begin
            sel  = sels[$urandom_range(2)];
            kind = $urandom_range(9);
            a    = 32'(($urandom_range(15)) * 4);
            d    = $urandom;
            we   = $urandom_range(1);
            re   = !we;
            if (kind == 0) a = a + 32'($urandom_range(3, 1));
            else if (kind == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            else if (kind == 2) begin we = 1'b1; re = 1'b1; end
            if (pending && prev_sel != sel) idle("rnd_switch", prev_sel);
            txn("random", sel, a, d, we, re, bit'($urandom_range(3) == 0));
            pending = 1'b1;
            if ($urandom_range(1) == 1) begin
                idle("random", sel);
                pending = 1'b0;
            end
            prev_sel = sel;
        end
        if (pending) idle("rnd_end", prev_sel);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
